// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch controller: FSM states, redirect-source select
// and the default sequential fetch increment.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_PEND = 2'd0,
    SRC_BR   = 2'd1,
    SRC_JMP  = 2'd2,
    SRC_SEQ  = 2'd3
  } src_e;

  localparam int unsigned DEF_PC_INC = 4;

  // A held redirect is older than anything currently in ID, so it goes first.
  function automatic src_e pick_src(input logic pend_vld, input logic br, input logic jmp);
    if (pend_vld)  return SRC_PEND;
    else if (br)   return SRC_BR;
    else if (jmp)  return SRC_JMP;
    else           return SRC_SEQ;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (clr_i)
      cnt_o <= '0;
    else if (inc_i && (cnt_o != '1))
      cnt_o <= cnt_o + CNT_W'(1);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Next-PC sequencer and stall/flush controller; Mealy outputs from registered
// state plus current hazard/redirect inputs, with saturating perf counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int unsigned      PC_INC   = DEF_PC_INC,
  parameter int unsigned      CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic             icache_stall_i,
  input  logic             dcache_stall_i,
  input  logic             load_use_i,
  input  logic             branch_taken_i,
  input  logic [XLEN-1:0]  branch_target_i,
  input  logic             jump_i,
  input  logic [XLEN-1:0]  jump_target_i,
  output logic [XLEN-1:0]  pc_next_o,
  output logic             pc_we_o,
  output logic             stall_o,
  output logic             flush_ifid_o,
  output logic             bubble_idex_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  state_e            state_q, state_d;
  logic              pend_vld_q, pend_vld_d;
  logic [XLEN-1:0]   pend_tgt_q, pend_tgt_d;
  logic              mem_stall;
  logic              stall_inc, flush_inc;
  src_e              src;

  assign mem_stall = icache_stall_i | dcache_stall_i;
  assign state_o   = state_q;

  always_comb begin
    pc_next_o     = pc_i;
    pc_we_o       = 1'b0;
    stall_o       = 1'b0;
    flush_ifid_o  = 1'b0;
    bubble_idex_o = 1'b0;
    state_d       = state_q;
    pend_vld_d    = pend_vld_q;
    pend_tgt_d    = pend_tgt_q;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    src           = SRC_SEQ;

    if (!start_i || (state_q == IDLE)) begin
      pc_next_o    = RESET_PC;
      pc_we_o      = 1'b1;
      flush_ifid_o = 1'b1;
      state_d      = start_i ? RUN : IDLE;
      if (!start_i)
        pend_vld_d = 1'b0;
    end else if (mem_stall) begin
      stall_o   = 1'b1;
      stall_inc = 1'b1;
      state_d   = MEM_WAIT;
      if (branch_taken_i) begin
        pend_vld_d = 1'b1;
        pend_tgt_d = branch_target_i;
      end else if (jump_i) begin
        pend_vld_d = 1'b1;
        pend_tgt_d = jump_target_i;
      end
    end else begin
      state_d = RUN;
      if (load_use_i) begin
        // ID will re-present any redirect next cycle, so it is dropped here.
        stall_o       = 1'b1;
        bubble_idex_o = 1'b1;
        stall_inc     = 1'b1;
      end else begin
        src     = pick_src(pend_vld_q, branch_taken_i, jump_i);
        pc_we_o = 1'b1;
        unique case (src)
          SRC_PEND: pc_next_o = pend_tgt_q;
          SRC_BR:   pc_next_o = branch_target_i;
          SRC_JMP:  pc_next_o = jump_target_i;
          default:  pc_next_o = pc_i + XLEN'(PC_INC);
        endcase
        if (src != SRC_SEQ) begin
          flush_ifid_o = 1'b1;
          flush_inc    = 1'b1;
          pend_vld_d   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .inc_i (stall_inc),
    .clr_i (rst_i),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .inc_i (flush_inc),
    .clr_i (rst_i),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: driver pushes reference-model expectations,
// monitor pops and compares on the falling edge.
module tb_fetch_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, start, ic, dc, lu, br, jmp;
  logic [XLEN-1:0]  pc_i, bt, jt;
  logic [XLEN-1:0]  pc_next;
  logic             pc_we, stall, flush, bubble;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .XLEN     (XLEN),
    .RESET_PC (32'h0000_0000),
    .PC_INC   (4),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .pc_i            (pc_i),
    .icache_stall_i  (ic),
    .dcache_stall_i  (dc),
    .load_use_i      (lu),
    .branch_taken_i  (br),
    .branch_target_i (bt),
    .jump_i          (jmp),
    .jump_target_i   (jt),
    .pc_next_o       (pc_next),
    .pc_we_o         (pc_we),
    .stall_o         (stall),
    .flush_ifid_o    (flush),
    .bubble_idex_o   (bubble),
    .state_o         (state),
    .stall_cnt_o     (stall_cnt),
    .flush_cnt_o     (flush_cnt)
  );

  typedef struct {
    bit          chk;
    logic [31:0] pc;
    bit          we, st, fl, bu;
    int unsigned state, sc, fc;
  } exp_t;

  exp_t q[$];
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Reference model: what the controller is doing, in plain terms.
  bit          running, waiting, have_pend, first = 1'b1;
  logic [31:0] pend_addr, pc_reg;
  int unsigned stalls, flushes;

  task automatic step(input logic r, s, i_st, d_st, l, b, j,
                      input logic [31:0] btgt, jtgt);
    exp_t e;
    bit   cnt_s, cnt_f;
    @(posedge clk);
    #1;
    rst = r; start = s; ic = i_st; dc = d_st; lu = l; br = b; jmp = j;
    bt = btgt; jt = jtgt; pc_i = pc_reg;

    e.chk = !first; first = 1'b0;
    e.state = !running ? 0 : (waiting ? 2 : 1);
    e.sc = stalls; e.fc = flushes;
    e.pc = pc_reg; e.we = 0; e.st = 0; e.fl = 0; e.bu = 0;
    cnt_s = 0; cnt_f = 0;

    if (!s || !running) begin
      e.pc = 32'h0; e.we = 1; e.fl = 1;
      if (!s) have_pend = 0;
      running = s; waiting = 0;
    end else if (i_st || d_st) begin
      e.st = 1; cnt_s = 1; waiting = 1;
      if (b) begin have_pend = 1; pend_addr = btgt; end
      else if (j) begin have_pend = 1; pend_addr = jtgt; end
    end else begin
      waiting = 0;
      if (l) begin
        e.st = 1; e.bu = 1; cnt_s = 1;
      end else if (have_pend || b || j) begin
        e.we = 1; e.fl = 1; cnt_f = 1;
        e.pc = have_pend ? pend_addr : (b ? btgt : jtgt);
        have_pend = 0;
      end else begin
        e.we = 1; e.pc = pc_reg + 32'd4;
      end
    end

    if (r) begin
      running = 0; waiting = 0; have_pend = 0; stalls = 0; flushes = 0;
    end else begin
      if (cnt_s && stalls < CMAX) stalls++;
      if (cnt_f && flushes < CMAX) flushes++;
    end
    if (e.we) pc_reg = e.pc;
    q.push_back(e);
  endtask

  task automatic seq(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) step(0, 1, 0, 0, 0, 0, 0, '0, '0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h want 0x%0h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          chk("pc_next",   pc_next,   e.pc);
          chk("pc_we",     32'(pc_we),  32'(e.we));
          chk("stall",     32'(stall),  32'(e.st));
          chk("flush",     32'(flush),  32'(e.fl));
          chk("bubble",    32'(bubble), 32'(e.bu));
          chk("state",     32'(state),  e.state);
          chk("stall_cnt", 32'(stall_cnt), e.sc);
          chk("flush_cnt", 32'(flush_cnt), e.fc);
        end
      end
    end
  end

  initial begin : driver
    rst = 1; start = 0; ic = 0; dc = 0; lu = 0; br = 0; jmp = 0;
    bt = '0; jt = '0; pc_i = '0;
    running = 0; waiting = 0; have_pend = 0; pend_addr = '0;
    pc_reg = '0; stalls = 0; flushes = 0;

    // Reset, then start: 0x0, 0x4, 0x8, 0xC, 0x10
    step(1, 0, 0, 0, 0, 0, 0, '0, '0);
    step(1, 0, 0, 0, 0, 0, 0, '0, '0);
    seq(5);
    // Icache stall for three cycles at 0x10, then resume at 0x14
    repeat (3) step(0, 1, 1, 0, 0, 0, 0, '0, '0);
    seq(2);
    // Branch arrives during a dcache stall; applied on first clear cycle
    step(0, 1, 0, 1, 0, 1, 0, 32'h40, 32'h999);
    step(0, 1, 0, 1, 0, 0, 0, '0, '0);
    seq(3);
    // Load-use with simultaneous branch, then branch alone
    step(0, 1, 0, 0, 1, 1, 0, 32'h80, '0);
    step(0, 1, 0, 0, 0, 1, 0, 32'h80, '0);
    seq(2);
    // Pending redirect discarded by start_i=0 in MEM_WAIT
    step(0, 1, 0, 1, 0, 0, 1, '0, 32'h100);
    step(0, 0, 0, 1, 0, 0, 0, '0, '0);
    step(0, 1, 0, 0, 0, 0, 0, '0, '0);
    seq(3);
    // Sequential wrap from the top of the address space
    pc_reg = 32'hFFFF_FFFC;
    seq(2);
    // Counter saturation, then reset clears it
    step(1, 1, 0, 0, 0, 0, 0, '0, '0);
    step(0, 1, 0, 0, 0, 0, 0, '0, '0);
    repeat (20) step(0, 1, 1, 0, 0, 0, 0, '0, '0);
    seq(2);
    step(1, 1, 0, 0, 0, 0, 0, '0, '0);
    seq(2);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) pc_reg = $urandom() & 32'hFFFF_FFFC;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 19) != 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 6) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 6) == 0,
           $urandom() & 32'hFFFF_FFFC, $urandom() & 32'hFFFF_FFFC);
    end

    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    if (q.size() > 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
